// File: rtl/fp_carpma.sv
// fp_carpma: sequential single-precision float multiplier.
// It multiplies the two 24-bit mantissas with an iterative shift-add loop and
// truncates the product. Operands and results move over a valid/ready handshake.
//
// state  | meaning
// IDLE   | ready; latch operands on gecerli_i
// UNPACK | split fields, form sign, exponent sum and special-case flags
// MUL    | one multiplier bit per cycle, 24 cycles
// NORM   | pick the mantissa window and adjust the exponent
// PACK   | resolve special cases, write c_o, pulse gecerli_o
module fp_carpma #(
  parameter int n = 32,
  parameter int e = 8,
  parameter int m = 23
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [n-1:0] g1_i,
  input  logic [n-1:0] g2_i,
  input  logic         gecerli_i,
  output logic         hazir_o,
  output logic [n-1:0] c_o,
  output logic         gecerli_o
);

  localparam int MW   = m + 1;
  localparam int PW   = 2 * MW;
  localparam int CW   = $clog2(MW);
  localparam int BIAS = (1 << (e - 1)) - 1;
  localparam int EMAX = (1 << e) - 1;

  localparam logic [CW-1:0]         CNT_LAST = CW'(MW - 1);
  localparam logic signed [e+1:0]   ES_MAX   = (e + 2)'(EMAX);
  localparam logic signed [e+1:0]   ES_ZERO  = '0;
  localparam logic signed [e+1:0]   ES_ONE   = (e + 2)'(1);
  localparam logic [n-1:0]          QNAN     = {1'b0, {e{1'b1}}, 1'b1, {(m - 1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_MUL,
    S_NORM,
    S_PACK
  } state_t;

  state_t                r_state;
  logic [n-1:0]          r_a;
  logic [n-1:0]          r_b;
  logic                  r_sign;
  logic signed [e+1:0]   r_es;
  logic [PW-1:0]         r_ma;
  logic [MW-1:0]         r_mb;
  logic [PW-1:0]         r_p;
  logic [CW-1:0]         r_cnt;
  logic [m-1:0]          r_mant;
  logic                  r_nan;
  logic                  r_inf;
  logic                  r_zero;
  logic [n-1:0]          r_c;
  logic                  r_vld;

  logic [e-1:0]  w_ea;
  logic [e-1:0]  w_eb;
  logic [m-1:0]  w_fa;
  logic [m-1:0]  w_fb;
  logic          w_a_zero;
  logic          w_b_zero;
  logic          w_a_inf;
  logic          w_b_inf;
  logic          w_a_nan;
  logic          w_b_nan;
  logic [e+1:0]  w_es_sum;

  // Field extraction and classification of the latched operands
  assign w_ea     = r_a[n-2:m];
  assign w_eb     = r_b[n-2:m];
  assign w_fa     = r_a[m-1:0];
  assign w_fb     = r_b[m-1:0];
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_inf  = (w_ea == {e{1'b1}}) && (w_fa == '0);
  assign w_b_inf  = (w_eb == {e{1'b1}}) && (w_fb == '0);
  assign w_a_nan  = (w_ea == {e{1'b1}}) && (w_fa != '0);
  assign w_b_nan  = (w_eb == {e{1'b1}}) && (w_fb != '0);
  // Modular sum; the 10-bit result is read back as two's complement
  assign w_es_sum = {2'b00, w_ea} + {2'b00, w_eb} - (e + 2)'(BIAS);

  assign hazir_o   = (r_state == S_IDLE);
  assign c_o       = r_c;
  assign gecerli_o = r_vld;

  // Controller and datapath: one register bank, stepped by the state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sign  <= 1'b0;
      r_es    <= '0;
      r_ma    <= '0;
      r_mb    <= '0;
      r_p     <= '0;
      r_cnt   <= '0;
      r_mant  <= '0;
      r_nan   <= 1'b0;
      r_inf   <= 1'b0;
      r_zero  <= 1'b0;
      r_c     <= '0;
      r_vld   <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (gecerli_i) begin
            r_a     <= g1_i;
            r_b     <= g2_i;
            r_p     <= '0;
            r_cnt   <= '0;
            r_state <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          r_sign <= r_a[n-1] ^ r_b[n-1];
          r_es   <= w_es_sum;
          r_ma   <= {{MW{1'b0}}, 1'b1, w_fa};
          r_mb   <= {1'b1, w_fb};
          r_nan  <= w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_a_zero & w_b_inf);
          r_inf  <= w_a_inf | w_b_inf;
          r_zero <= w_a_zero | w_b_zero;
          if (w_a_nan | w_b_nan | w_a_inf | w_b_inf | w_a_zero | w_b_zero)
            r_state <= S_PACK;
          else
            r_state <= S_MUL;
        end
        S_MUL: begin
          if (r_mb[0])
            r_p <= r_p + r_ma;
          r_ma  <= r_ma << 1;
          r_mb  <= r_mb >> 1;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST)
            r_state <= S_NORM;
        end
        S_NORM: begin
          if (r_p[PW-1]) begin
            r_mant <= r_p[PW-2:MW];
            r_es   <= r_es + ES_ONE;
          end else begin
            r_mant <= r_p[PW-3:MW-1];
          end
          r_state <= S_PACK;
        end
        S_PACK: begin
          if (r_nan)
            r_c <= QNAN;
          else if (r_inf)
            r_c <= {r_sign, {e{1'b1}}, {m{1'b0}}};
          else if (r_zero)
            r_c <= {r_sign, {(n - 1){1'b0}}};
          else if (r_es >= ES_MAX)
            r_c <= {r_sign, {e{1'b1}}, {m{1'b0}}};
          else if (r_es <= ES_ZERO)
            r_c <= {r_sign, {(n - 1){1'b0}}};
          else
            r_c <= {r_sign, r_es[e-1:0], r_mant};
          r_vld   <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_carpma.sv
// tb_fp_carpma: directed checks of the fp_carpma float multiplier.
module tb_fp_carpma;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] g1_i;
  logic [31:0] g2_i;
  logic        gecerli_i;
  logic        hazir_o;
  logic [31:0] c_o;
  logic        gecerli_o;

  int checks = 0;
  int errors = 0;

  fp_carpma #(.n(32), .e(8), .m(23)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .g1_i      (g1_i),
    .g2_i      (g2_i),
    .gecerli_i (gecerli_i),
    .hazir_o   (hazir_o),
    .c_o       (c_o),
    .gecerli_o (gecerli_o)
  );

  // 10 ns clock
  always #5 clk_i = ~clk_i;

  // Compare and count
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction: present, accept, measure latency, check result and hold
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    int bad_hz;
    logic [31:0] held;
    @(negedge clk_i);
    check({tag, "_ready"}, 32'(hazir_o), 32'd1);
    g1_i      = a;
    g2_i      = b;
    gecerli_i = 1'b1;
    @(posedge clk_i);
    #1;
    gecerli_i = 1'b0;
    g1_i      = $urandom;
    g2_i      = $urandom;
    bad_hz    = hazir_o ? 1 : 0;
    lat       = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk_i);
      #1;
      if (gecerli_o) begin
        lat = k;
        break;
      end
      if (hazir_o) bad_hz++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_c"}, c_o, exp);
    check({tag, "_busy"}, 32'(bad_hz), 32'd0);
    check({tag, "_rdy_res"}, 32'(hazir_o), 32'd1);
    held = c_o;
    @(posedge clk_i);
    #1;
    check({tag, "_pulse1"}, 32'(gecerli_o), 32'd0);
    check({tag, "_hold"}, c_o, held);
  endtask

  logic [31:0] ta [3] = '{32'h40000000, 32'h3FC00000, 32'hC0800000};
  logic [31:0] tb [3] = '{32'h40400000, 32'h3FC00000, 32'h3F000000};
  logic [31:0] te [3] = '{32'h40C00000, 32'h40100000, 32'hC0000000};

  // Directed sequence
  initial begin
    int pulses;
    int idx;
    int nres;
    int last;
    rst_i     = 1'b1;
    gecerli_i = 1'b0;
    g1_i      = '0;
    g2_i      = '0;
    #1;
    check("rst_c", c_o, 32'h0);
    check("rst_vld", 32'(gecerli_o), 32'd0);
    check("rst_rdy", 32'(hazir_o), 32'd1);
    @(negedge clk_i);
    rst_i = 1'b0;

    run_op("mul_2x3",    32'h40000000, 32'h40400000, 32'h40C00000, 27);
    run_op("mul_15x15",  32'h3FC00000, 32'h3FC00000, 32'h40100000, 27);
    run_op("mul_m4x05",  32'hC0800000, 32'h3F000000, 32'hC0000000, 27);
    run_op("zero_x_neg", 32'h00000000, 32'hC2C80000, 32'h80000000, 2);
    run_op("inf_x_zero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 2);
    run_op("ninf_x_2",   32'hFF800000, 32'h40000000, 32'hFF800000, 2);
    run_op("nan_x_1",    32'h7FC00001, 32'h3F800000, 32'h7FC00000, 2);
    run_op("underflow",  32'h00800000, 32'h00800000, 32'h00000000, 27);
    run_op("overflow",   32'h7F000000, 32'h7F000000, 32'h7F800000, 27);

    // Asynchronous reset in the middle of MUL
    @(negedge clk_i);
    g1_i      = 32'h40000000;
    g2_i      = 32'h40400000;
    gecerli_i = 1'b1;
    @(posedge clk_i);
    #1;
    gecerli_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    #1;
    check("arst_c", c_o, 32'h0);
    check("arst_vld", 32'(gecerli_o), 32'd0);
    check("arst_rdy", 32'(hazir_o), 32'd1);
    @(negedge clk_i);
    rst_i  = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (gecerli_o) pulses++;
    end
    check("arst_no_pulse", 32'(pulses), 32'd0);
    run_op("after_rst", 32'h40000000, 32'h40400000, 32'h40C00000, 27);

    // Continuous valid with changing operands
    idx  = 0;
    nres = 0;
    last = -1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk_i);
      if (gecerli_o) begin
        if (nres < 3) check($sformatf("stream_c%0d", nres), c_o, te[nres]);
        if (last >= 0) check($sformatf("stream_gap%0d", nres), 32'(cyc - last), 32'd28);
        last = cyc;
        nres++;
      end
      if (hazir_o) begin
        if (idx < 3) begin
          g1_i      = ta[idx];
          g2_i      = tb[idx];
          gecerli_i = 1'b1;
          idx++;
        end else begin
          gecerli_i = 1'b0;
        end
      end else begin
        g1_i      = $urandom;
        g2_i      = $urandom;
        gecerli_i = 1'b1;
      end
    end
    check("stream_count", 32'(nres), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog against a hung run
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d checks", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fp_carpma.md
Name: fp_carpma

Overview:
- Sequential IEEE-754 single-precision multiplier, directly downstream of the integer-to-float converter.
- Consumes the 32-bit floats the converter produces (sign | 8-bit exponent | 23-bit mantissa) and multiplies two of them with an iterative shift-add mantissa datapath.
- Uses truncation rounding, matching the converter's truncating behaviour.
- Transfers use a simple valid/ready handshake so it can be chained after the converter or any float source.

Parameters:
- n, 32, total float width
- e, 8, exponent width
- m, 23, stored mantissa width (hidden bit excluded)

Ports:
- clk_i  input  1  clock; all state changes on the rising edge
- rst_i  input  1  reset, asynchronous, active-high
- g1_i  input  n  operand A, float
- g2_i  input  n  operand B, float
- gecerli_i  input  1  operands valid; accepted when gecerli_i and hazir_o are both 1 at a rising edge
- hazir_o  output  1  ready; 1 only in state IDLE
- c_o  output  n  product, float; holds the last result until the next result is written
- gecerli_o  output  1  one-cycle pulse, high in the cycle c_o is updated

Behaviour:
- Reset: asserting rst_i forces, immediately and asynchronously, state=IDLE, c_o=0, gecerli_o=0, hazir_o=1, and clears the iteration counter and accumulator.
- Reset mid-operation aborts the operation; no gecerli_o pulse follows for the aborted operation.
- States are IDLE, UNPACK, MUL, NORM, PACK.
- IDLE: hazir_o=1. On the accepting edge E0, latch g1_i/g2_i and go to UNPACK.
- gecerli_i in any other state is ignored; operands are not queued.
- UNPACK (edge E1):
  - Compute sign = A[31] xor B[31].
  - Form 24-bit mantissas with hidden bit 1.
  - Compute exponent sum es = eA + eB - 127 in a 10-bit signed register.
  - Classify: exponent field 0 is zero (denormals flushed to zero); exponent 255 with mantissa 0 is inf; exponent 255 with mantissa nonzero is NaN.
  - Any special case goes to PACK; otherwise go to MUL.
- MUL: 24 iterations on edges E2..E25. Each iteration examines one multiplier bit from LSB upward; if the bit is 1, add the shifted multiplicand into the 48-bit accumulator P. After the 24th iteration, go to NORM.
- NORM (E26):
  - If P[47]=1: mantissa = P[46:24], es = es + 1.
  - Else: mantissa = P[45:23].
  - Lower bits are discarded (truncate toward zero).
- PACK (E27 regular, E2 special): write c_o, pulse gecerli_o=1, go to IDLE. hazir_o is already 1 in that same cycle, so back-to-back acceptance is allowed.
- Result priority in PACK:
  1. NaN input, or inf times zero, gives 0x7FC00000.
  2. Otherwise any inf input gives {sign, 0xFF, 0}.
  3. Otherwise any zero input gives {sign, 0, 0}.
  4. Otherwise es >= 255 gives {sign, 0xFF, 0} (overflow).
  5. Otherwise es <= 0 gives {sign, 0, 0} (underflow flush).
  6. Otherwise {sign, es[7:0], mantissa}.
- Latency: gecerli_o is high in the cycle after edge E0+27 (regular) or E0+2 (special). Latency is fixed and independent of operand values.
- gecerli_o is never high for two consecutive cycles.

Test Plan:
- 0x40000000 (2.0) × 0x40400000 (3.0) -> c_o=0x40C00000; gecerli_o pulses exactly 27 edges after acceptance; hazir_o=0 from E0 until the result cycle.
- 0x3FC00000 × 0x3FC00000 (1.5×1.5, P[47]=1 path) -> 0x40100000; 0xC0800000 × 0x3F000000 (-4.0×0.5) -> 0xC0000000.
- 0x00000000 × 0xC2C80000 -> 0x80000000 after 2 edges; 0x7F800000 × 0x00000000 -> 0x7FC00000; 0xFF800000 × 0x40000000 -> 0xFF800000.
- 0x7F000000 × 0x7F000000 -> 0x7F800000 (overflow); 0x00800000 × 0x00800000 -> 0x00000000 (underflow).
- Assert rst_i for one cycle during MUL (10 edges after acceptance) -> c_o=0, gecerli_o=0, hazir_o=1 without waiting for a clock edge; no later gecerli_o pulse. A new 2.0×3.0 afterwards gives 0x40C00000.
- Hold gecerli_i=1 continuously with changing operands -> only operands present on the edges where hazir_o=1 are used; successive results arrive 28 cycles apart with no lost or duplicated pulses.
